mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the hart's load/store/fetch traffic. It owns a word-organised RAM array with a write-protected ROM window at low addresses.
- Accepts one request at a time over a valid/ready handshake. Writes with byte/halfword/word width. Returns read data after a fixed latency.
- Replaces the bare combinational memory port with an explicit request/response protocol that reports alignment and access errors.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, total words in the array; valid byte addresses are 0 .. DEPTH_WORDS*4-1.
- ROM_WORDS, 256, words [0, ROM_WORDS) are read-only; contents come from the init file.
- READ_LATENCY, 2, cycles between read acceptance and resp_valid; minimum 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_addr  in  XLEN  byte address.
- req_width  in  2  write_width_t: write_byte=0, write_halfword=1, write_word=2; 3 is illegal. Also used for read alignment checks.
- req_wdata  in  XLEN  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle pulse; the response is valid this cycle.
- resp_rdata  out  XLEN  read data, right-aligned, zero-filled above the access width.
- resp_error  out  1  qualified by resp_valid; the access was rejected.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, req_ready=0 while asserted, resp_valid=0, resp_rdata=0, resp_error=0, latency counter=0.
  - Array contents are not cleared.
  - A read in flight is aborted and no response is issued.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid, the request is accepted and addr/width/write/wdata are latched.
    - Write → WRITE. Read → READ_WAIT with counter=READ_LATENCY-1.
  - WRITE:
    - req_ready=0.
    - The array update (if legal) happens at this cycle's clock edge.
    - Next state RESP.
  - READ_WAIT:
    - req_ready=0.
    - Counter decrements each cycle.
    - When the counter is 0, the addressed word is registered into the response data register; next state RESP.
  - RESP:
    - resp_valid=1 for exactly one cycle; req_ready=0.
    - Next state IDLE.
    - resp_rdata and resp_error hold their values until the next RESP. resp_rdata=0 after any write response.
- Latency:
  - Read: resp_valid rises READ_LATENCY+1 edges after acceptance (3 cycles at default).
  - Write: resp_valid rises 2 edges after acceptance.
  - Next acceptance is possible in the cycle after RESP; maximum throughput is one request per READ_LATENCY+2 cycles.
- Error conditions (any one sets resp_error=1):
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - req_width=3.
  - addr ≥ DEPTH_WORDS*4 (out of range).
  - Write with word index < ROM_WORDS (ROM protect). Reads of ROM are legal.
  - On error: no array write occurs, resp_rdata=0, and the timing is identical to a legal access of the same type.
- Write lane merge:
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Halfword: lanes addr[1]*2 .. +1 ← wdata[15:0].
  - Word: all lanes.
  - Untouched lanes keep their old value.
- Read extract:
  - Word shifted right by addr[1:0]*8, then masked to 8/16/32 bits per width.
  - Sign extension is the hart's job.
- Simultaneity: req_valid outside IDLE is ignored (not queued). The requester must hold its request until it sees req_ready=1.
- Request fields are sampled only at acceptance; later changes have no effect.

Test Plan:
- Reset mid-read: accept a read at 0x400, drop reset 1 cycle later → resp_valid never pulses; after release, req_ready=1 and resp_rdata=0.
- Word write then read: write 0xDEADBEEF to 0x400 → resp_valid 2 cycles later with error=0. Word read of 0x400 → resp_valid 3 cycles after acceptance with rdata 0xDEADBEEF.
- Byte/halfword merge and extract:
  - Write byte 0x11 to 0x401, then halfword 0x2233 to 0x402.
  - Word read of 0x400 → 0x223311EF.
  - Byte read of 0x403 → 0x00000022.
  - Halfword read of 0x402 → 0x00002233.
- Errors:
  - Halfword write to 0x401 → error=1, and a later word read of 0x400 is unchanged.
  - Word read at 0x1000 (DEPTH 1024) → error=1, rdata=0.
  - req_width=3 → error=1.
- ROM protect: word write 0x12345678 to 0x10 → error=1. Read of 0x10 still returns the init-file value with error=0.
- Back-to-back and ignored requests:
  - Hold req_valid high with two queued reads → second accepted only in the cycle after the first resp_valid.
  - req_valid pulses during READ_WAIT produce no extra responses.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: single-outstanding valid/ready request port onto a word RAM
// with a write-protected low ROM window, fixed read latency and error reporting.
module mem_responder #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned ROM_WORDS    = 256,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_width,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error
);

    typedef enum logic [1:0] {
        WRITE_BYTE     = 2'd0,
        WRITE_HALFWORD = 2'd1,
        WRITE_WORD     = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RESP
    } state_t;

    localparam int unsigned      AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned      CW         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [XLEN-1:0]  BYTE_LIMIT = XLEN'(DEPTH_WORDS * 4);
    localparam logic [XLEN-1:0]  ROM_LIMIT  = XLEN'(ROM_WORDS);
    localparam logic [CW-1:0]    CNT_LOAD   = CW'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              write_q;
    logic [XLEN-1:0]   addr_q;
    logic [1:0]        width_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              error_q;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic              accept;
    logic              access_err;
    logic [AW-1:0]     idx;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   lane_mask;
    logic [XLEN-1:0]   read_mask;
    logic [XLEN-1:0]   merged;
    logic [XLEN-1:0]   read_val;

    assign accept = (state_q == IDLE) && req_valid;
    assign idx    = addr_q[AW+1:2];
    assign shamt  = {addr_q[1:0], 3'b000};

    // All error sources are judged on the latched request, so timing never depends on legality.
    always_comb begin
        access_err = 1'b0;
        case (width_q)
            WRITE_BYTE:     access_err = 1'b0;
            WRITE_HALFWORD: access_err = addr_q[0];
            WRITE_WORD:     access_err = (addr_q[1:0] != 2'b00);
            default:        access_err = 1'b1;
        endcase
        if (addr_q >= BYTE_LIMIT)
            access_err = 1'b1;
        if (write_q && ((addr_q >> 2) < ROM_LIMIT))
            access_err = 1'b1;
    end

    always_comb begin
        lane_mask = '0;
        read_mask = '0;
        case (width_q)
            WRITE_BYTE: begin
                lane_mask = XLEN'(8'hFF) << shamt;
                read_mask = XLEN'(8'hFF);
            end
            WRITE_HALFWORD: begin
                lane_mask = XLEN'(16'hFFFF) << shamt;
                read_mask = XLEN'(16'hFFFF);
            end
            WRITE_WORD: begin
                lane_mask = '1;
                read_mask = '1;
            end
            default: begin
                lane_mask = '0;
                read_mask = '0;
            end
        endcase
        merged   = (mem[idx] & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
        read_val = (mem[idx] >> shamt) & read_mask;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = reset;
                if (req_valid)
                    state_d = req_write ? WRITE : READ_WAIT;
            end
            WRITE:     state_d = RESP;
            READ_WAIT: if (cnt_q == '0) state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            width_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                width_q <= req_width;
                wdata_q <= req_wdata;
                cnt_q   <= CNT_LOAD;
            end
            if (state_q == WRITE) begin
                rdata_q <= '0;
                error_q <= access_err;
            end
            if (state_q == READ_WAIT) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    rdata_q <= access_err ? '0 : read_val;
                    error_q <= access_err;
                end
            end
        end
    end

    // Array has no reset: contents survive reset, ROM window is only guarded against writes.
    always_ff @(posedge clock) begin
        if ((state_q == WRITE) && !access_err)
            mem[idx] <= merged;
    end

    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a byte-addressed reference model.
module tb_mem_responder;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [1:0]  req_width = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] model [int unsigned];

    mem_responder #(
        .XLEN(32),
        .DEPTH_WORDS(1024),
        .ROM_WORDS(256),
        .READ_LATENCY(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_width(req_width),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_error(resp_error)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit w, input logic [31:0] a, input logic [1:0] wd);
        int unsigned size;
        if (wd == 2'd3) return 1'b1;
        size = 32'd1 << wd;
        if ((a % size) != 0) return 1'b1;
        if (a >= 32'd4096) return 1'b1;
        if (w && (a / 4) < 256) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] wd,
                                               output bit known);
        logic [31:0] v;
        int unsigned size;
        v     = '0;
        known = 1'b1;
        size  = 32'd1 << wd;
        for (int unsigned i = 0; i < size; i++) begin
            if (model.exists(a + i)) v |= 32'(model[a + i]) << (8 * i);
            else known = 1'b0;
        end
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] wd, input logic [31:0] d);
        int unsigned size;
        size = 32'd1 << wd;
        for (int unsigned i = 0; i < size; i++)
            model[a + i] = d[8*i +: 8];
    endtask

    // One complete transaction; fields are scrambled right after acceptance.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [1:0] wd,
                        input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n;
        bit got, busy_ready, known, e_err;
        logic [31:0] e_rd;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_addr = a; req_width = wd; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_width = 2'($urandom);
        req_wdata = $urandom;
        n = 0; got = 1'b0; busy_ready = 1'b0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (resp_valid) got = 1'b1;
            if (req_ready) busy_ready = 1'b1;
        end
        chk("latency", 32'(n), w ? 32'd2 : 32'd3);
        chk("ready_low_while_busy", 32'(busy_ready), 32'd0);
        rd = resp_rdata;
        er = resp_error;
        e_err = model_err(w, a, wd);
        e_rd  = (w || e_err) ? 32'd0 : model_read(a, wd, known);
        chk("resp_error", 32'(er), 32'(e_err));
        if (w || e_err || known)
            chk("resp_rdata", rd, e_rd);
        @(negedge clock);
        chk("resp_valid_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        chk("rdata_held", resp_rdata, rd);
        if (w && !e_err) model_write(a, wd, d);
    endtask

    initial begin
        logic [31:0] rd, rom_before, a, d;
        logic        er;
        logic [1:0]  wd;
        bit          w, got, known;
        int          n, first_resp, first_ready, pulses, sel;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_error", 32'(resp_error), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Reset while a read is in flight
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; req_width = 2'd2;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        got = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid) got = 1'b1;
            chk("ready_in_rst", 32'(req_ready), 32'd0);
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (resp_valid) got = 1'b1;
        end
        chk("abort_no_resp", 32'(got), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rdata", resp_rdata, 32'd0);

        // Word write / read
        xfer(1'b1, 32'h400, 2'd2, 32'hDEADBEEF, rd, er);
        chk("ww_err", 32'(er), 32'd0);
        xfer(1'b0, 32'h400, 2'd2, 32'h0, rd, er);
        chk("wr_data", rd, 32'hDEADBEEF);

        // Lane merge and extract
        xfer(1'b1, 32'h401, 2'd0, 32'hFFFFFF11, rd, er);
        xfer(1'b1, 32'h402, 2'd1, 32'hFFFF2233, rd, er);
        xfer(1'b0, 32'h400, 2'd2, 32'h0, rd, er);
        chk("merge_word", rd, 32'h223311EF);
        xfer(1'b0, 32'h403, 2'd0, 32'h0, rd, er);
        chk("byte_extract", rd, 32'h00000022);
        xfer(1'b0, 32'h402, 2'd1, 32'h0, rd, er);
        chk("half_extract", rd, 32'h00002233);

        // Errors
        xfer(1'b1, 32'h401, 2'd1, 32'h0000AAAA, rd, er);
        chk("misaligned_write_err", 32'(er), 32'd1);
        xfer(1'b0, 32'h400, 2'd2, 32'h0, rd, er);
        chk("misaligned_unchanged", rd, 32'h223311EF);
        xfer(1'b0, 32'h1000, 2'd2, 32'h0, rd, er);
        chk("oob_err", 32'(er), 32'd1);
        chk("oob_rdata", rd, 32'd0);
        xfer(1'b0, 32'h404, 2'd3, 32'h0, rd, er);
        chk("width3_read_err", 32'(er), 32'd1);
        xfer(1'b1, 32'h404, 2'd3, 32'h55555555, rd, er);
        chk("width3_write_err", 32'(er), 32'd1);

        // Top of the array and ROM boundary
        xfer(1'b1, 32'hFFC, 2'd2, 32'hA5A55A5A, rd, er);
        xfer(1'b0, 32'hFFF, 2'd0, 32'h0, rd, er);
        chk("top_byte", rd, 32'h000000A5);
        xfer(1'b1, 32'h3FC, 2'd2, 32'h0BADF00D, rd, er);
        chk("rom_last_word_err", 32'(er), 32'd1);

        // ROM protect
        xfer(1'b0, 32'h10, 2'd2, 32'h0, rom_before, er);
        chk("rom_read_err", 32'(er), 32'd0);
        xfer(1'b1, 32'h10, 2'd2, 32'h12345678, rd, er);
        chk("rom_write_err", 32'(er), 32'd1);
        xfer(1'b0, 32'h10, 2'd2, 32'h0, rd, er);
        chk("rom_read_err2", 32'(er), 32'd0);
        chk("rom_unchanged", rd, rom_before);

        // Fill the RAM test window, then randomized traffic
        for (int i = 1; i < 16; i++)
            xfer(1'b1, 32'h400 + 32'(4 * i), 2'd2, $urandom, rd, er);
        for (int k = 0; k < 60; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = 32'h400 + 32'($urandom_range(0, 63));
            else if (sel == 7) a = 32'h1000 + 32'($urandom_range(0, 255));
            else               a = 32'($urandom_range(0, 32'h3FF));
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            w  = 1'($urandom_range(0, 1));
            wd = 2'($urandom_range(0, 3));
            d  = $urandom;
            xfer(w, a, wd, d, rd, er);
        end

        // Held req_valid: second read accepted only after the first response
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40C; req_width = 2'd2;
        chk("b2b_ready_first", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 req_addr = 32'h410;
        n = 0; first_resp = 0; first_ready = 0;
        while (first_ready == 0 && n < 20) begin
            @(negedge clock);
            n++;
            if (resp_valid && first_resp == 0) begin
                first_resp = n;
                chk("b2b_first_data", resp_rdata, model_read(32'h40C, 2'd2, known));
            end
            if (req_ready) first_ready = n;
        end
        chk("b2b_first_resp_cycle", 32'(first_resp), 32'd3);
        chk("b2b_second_accept_cycle", 32'(first_ready), 32'd4);
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (resp_valid) got = 1'b1;
        end
        chk("b2b_second_latency", 32'(n), 32'd3);
        chk("b2b_second_data", resp_rdata, model_read(32'h410, 2'd2, known));

        // req_valid pulses during READ_WAIT are ignored
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h408; req_width = 2'd2;
        @(posedge clock);
        #1;
        req_write = 1'b1; req_wdata = 32'hFFFFFFFF;
        pulses = 0; first_resp = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            req_valid = (c == 1);
            if (resp_valid) begin
                pulses++;
                if (first_resp == 0) first_resp = c;
            end
        end
        chk("ignored_pulse_count", 32'(pulses), 32'd1);
        chk("ignored_resp_cycle", 32'(first_resp), 32'd3);
        xfer(1'b0, 32'h408, 2'd2, 32'h0, rd, er);
        chk("ignored_no_write", rd, model_read(32'h408, 2'd2, known));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
